// File: rtl/cache_ctrl_nway_if.sv
// CPU-side and memory-side handshake bundle for the N-way write-back cache controller.
// slave = controller view, master = CPU/memory environment view.
interface cache_ctrl_nway_if #(
  parameter int ADR_WIDTH  = 32,
  parameter int DATA_WIDTH = 32
);
  // Handshakes are request/acknowledge rather than valid/ready:
  // - CPU side: req_cpu2cc is held with stable adr/dat/rdwr until ack_cc2cpu pulses
  //   for one cycle; it must then drop before the next request is accepted.
  // - Memory side: req_cc2mem with wr/adr/dat is held stable until an edge where
  //   ack_mem2cc=1, which transfers exactly one word (dat_mem2cc valid with the ack).
  logic                  req_cpu2cc;
  logic [ADR_WIDTH-1:0]  adr_cpu2cc;
  logic [DATA_WIDTH-1:0] dat_cpu2cc;
  logic                  rdwr_cpu2cc;
  logic                  ack_cc2cpu;
  logic [DATA_WIDTH-1:0] dat_cc2cpu;
  logic                  req_cc2mem;
  logic                  wr_cc2mem;
  logic [ADR_WIDTH-1:0]  adr_cc2mem;
  logic [DATA_WIDTH-1:0] dat_cc2mem;
  logic                  ack_mem2cc;
  logic [DATA_WIDTH-1:0] dat_mem2cc;

  modport slave (
    input  req_cpu2cc, adr_cpu2cc, dat_cpu2cc, rdwr_cpu2cc, ack_mem2cc, dat_mem2cc,
    output ack_cc2cpu, dat_cc2cpu, req_cc2mem, wr_cc2mem, adr_cc2mem, dat_cc2mem
  );

  modport master (
    output req_cpu2cc, adr_cpu2cc, dat_cpu2cc, rdwr_cpu2cc, ack_mem2cc, dat_mem2cc,
    input  ack_cc2cpu, dat_cc2cpu, req_cc2mem, wr_cc2mem, adr_cc2mem, dat_cc2mem
  );
endinterface

// File: rtl/cache_ctrl_nway.sv
// Write-back N-way set-associative cache controller with word-serial line refill/eviction.
// Victim = lowest invalid way, else the per-set round-robin pointer.
module cache_ctrl_nway #(
  parameter int ADR_WIDTH   = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int WORD_OFFSET = 2,
  parameter int INDEX_WIDTH = 6,
  parameter int WAYS        = 4
) (
  input  logic                clk,
  input  logic                rst,
  cache_ctrl_nway_if.slave    bus,
  output logic [2:0]          o_dbg_state
);
  localparam int WORDS = 2 ** WORD_OFFSET;
  localparam int SETS  = 2 ** INDEX_WIDTH;
  localparam int TAG_W = ADR_WIDTH - INDEX_WIDTH - WORD_OFFSET - 2;
  localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOOKUP  = 3'd1,
    S_EVICT   = 3'd2,
    S_REFILL  = 3'd3,
    S_RESPOND = 3'd4,
    S_RELEASE = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [TAG_W-1:0]       r_ltag;
  logic [INDEX_WIDTH-1:0] r_idx;
  logic [WORD_OFFSET-1:0] r_word;
  logic [DATA_WIDTH-1:0]  r_wdat;
  logic                   r_rdwr;
  logic [WW-1:0]          r_way;
  logic [WORD_OFFSET-1:0] r_cnt;

  logic [TAG_W-1:0]      r_tags  [WAYS][SETS];
  logic [DATA_WIDTH-1:0] r_data  [WAYS][SETS][WORDS];
  logic [SETS-1:0]       r_valid [WAYS];
  logic [SETS-1:0]       r_dirty [WAYS];
  logic [WW-1:0]         r_rr    [SETS];

  logic          w_hit;
  logic [WW-1:0] w_hit_way;
  logic [WW-1:0] w_victim;
  logic          w_last;
  logic          w_mem_ack;

  // Descending scan so the lowest-numbered invalid way wins.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_victim  = r_rr[r_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w][r_idx]) w_victim = WW'(w);
    end
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w][r_idx] && (r_tags[w][r_idx] == r_ltag)) begin
        w_hit     = 1'b1;
        w_hit_way = WW'(w);
      end
    end
  end

  assign w_last    = (r_cnt == '1);
  assign w_mem_ack = bus.ack_mem2cc && ((r_state == S_EVICT) || (r_state == S_REFILL));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (bus.req_cpu2cc) w_next = S_LOOKUP;
      S_LOOKUP: begin
        if (w_hit)                                               w_next = S_RESPOND;
        else if (r_valid[w_victim][r_idx] && r_dirty[w_victim][r_idx]) w_next = S_EVICT;
        else                                                     w_next = S_REFILL;
      end
      S_EVICT:   if (w_mem_ack && w_last) w_next = S_REFILL;
      S_REFILL:  if (w_mem_ack && w_last) w_next = S_RESPOND;
      S_RESPOND: w_next = S_RELEASE;
      S_RELEASE: if (!bus.req_cpu2cc) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.ack_cc2cpu = 1'b0;
    bus.dat_cc2cpu = '0;
    bus.req_cc2mem = 1'b0;
    bus.wr_cc2mem  = 1'b0;
    bus.adr_cc2mem = '0;
    bus.dat_cc2mem = '0;
    case (r_state)
      S_RESPOND: begin
        bus.ack_cc2cpu = 1'b1;
        if (!r_rdwr) bus.dat_cc2cpu = r_data[r_way][r_idx][r_word];
      end
      S_EVICT: begin
        bus.req_cc2mem = 1'b1;
        bus.wr_cc2mem  = 1'b1;
        bus.adr_cc2mem = {r_tags[r_way][r_idx], r_idx, r_cnt, 2'b00};
        bus.dat_cc2mem = r_data[r_way][r_idx][r_cnt];
      end
      S_REFILL: begin
        bus.req_cc2mem = 1'b1;
        bus.adr_cc2mem = {r_ltag, r_idx, r_cnt, 2'b00};
      end
      default: ;
    endcase
  end

  assign o_dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ltag  <= '0;
      r_idx   <= '0;
      r_word  <= '0;
      r_wdat  <= '0;
      r_rdwr  <= 1'b0;
      r_way   <= '0;
      r_cnt   <= '0;
      for (int w = 0; w < WAYS; w++) begin
        r_valid[w] <= '0;
        r_dirty[w] <= '0;
      end
      for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (bus.req_cpu2cc) begin
          {r_ltag, r_idx, r_word} <= bus.adr_cpu2cc[ADR_WIDTH-1:2];
          r_wdat <= bus.dat_cpu2cc;
          r_rdwr <= bus.rdwr_cpu2cc;
        end
        S_LOOKUP: begin
          r_way <= w_hit ? w_hit_way : w_victim;
          r_cnt <= '0;
          if (w_hit && r_rdwr) r_dirty[w_hit_way][r_idx] <= 1'b1;
        end
        S_EVICT: if (w_mem_ack) r_cnt <= r_cnt + 1'b1;
        S_REFILL: if (w_mem_ack) begin
          r_cnt <= r_cnt + 1'b1;
          // Line becomes valid only once the final word lands.
          if (w_last) begin
            r_valid[r_way][r_idx] <= 1'b1;
            r_dirty[r_way][r_idx] <= r_rdwr;
            r_rr[r_idx]           <= (WAYS == 1) ? '0 : r_rr[r_idx] + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag/data arrays need no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if ((r_state == S_LOOKUP) && w_hit && r_rdwr)
      r_data[w_hit_way][r_idx][r_word] <= r_wdat;
    if ((r_state == S_REFILL) && w_mem_ack) begin
      r_data[r_way][r_idx][r_cnt] <= bus.dat_mem2cc;
      if (w_last) begin
        r_tags[r_way][r_idx] <= r_ltag;
        if (r_rdwr) r_data[r_way][r_idx][r_word] <= r_wdat;
      end
    end
  end
endmodule

// File: tb/tb_cache_ctrl_nway.sv
// Directed bench for cache_ctrl_nway: hits, misses, dirty eviction, memory stalls,
// held CPU request and mid-refill reset, against a small memory image.
module tb_cache_ctrl_nway;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  cache_ctrl_nway_if #(.ADR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  cache_ctrl_nway #(
    .ADR_WIDTH(32), .DATA_WIDTH(32), .WORD_OFFSET(2), .INDEX_WIDTH(6), .WAYS(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mem_cyc  = 0;
  int t_req    = 0;
  int m_req    = 0;
  logic [31:0] mem_m [0:4095];
  logic [31:0] exp_q [$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.req_cc2mem) mem_cyc <= mem_cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic cpu_start(input logic [31:0] a, input logic [31:0] d, input logic wr);
    bus.adr_cpu2cc  = a;
    bus.dat_cpu2cc  = d;
    bus.rdwr_cpu2cc = wr;
    bus.req_cpu2cc  = 1'b1;
    t_req = cyc;
    m_req = mem_cyc;
  endtask

  // Serves n word handshakes starting at base; stall idle cycles precede every word but the first.
  task automatic mem_serve(input int n, input logic wr, input logic [31:0] base,
                           input int stall, input logic no_gap);
    logic [31:0] exp;
    for (int i = 0; i < n; i++) begin
      int waited = 0;
      logic [31:0] a = base + 32'(4 * i);
      if (i == 0 && !no_gap)
        while (!bus.req_cc2mem && waited < 50) begin
          @(negedge clk);
          waited++;
        end
      if (i > 0 && stall > 0) begin
        bus.ack_mem2cc = 1'b0;
        repeat (stall) begin
          @(negedge clk);
          check_eq("stall_req", {31'd0, bus.req_cc2mem}, 32'd1);
          check_eq("stall_adr", bus.adr_cc2mem, a);
        end
      end
      check_eq("mem_req", {31'd0, bus.req_cc2mem}, 32'd1);
      check_eq("mem_wr", {31'd0, bus.wr_cc2mem}, {31'd0, wr});
      check_eq("mem_adr", bus.adr_cc2mem, a);
      if (wr) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
        check_eq("wb_dat", bus.dat_cc2mem, exp);
        mem_m[a[13:2]] = exp;
        bus.dat_mem2cc = 32'h0;
      end else begin
        bus.dat_mem2cc = mem_m[a[13:2]];
      end
      bus.ack_mem2cc = 1'b1;
      @(negedge clk);
    end
    bus.ack_mem2cc = 1'b0;
  endtask

  task automatic wait_ack(input string tag, input int hold, input logic is_rd,
                          input logic [31:0] exp_dat, input int exp_lat, input logic is_hit);
    int n = 0;
    int extra = 0;
    while (!bus.ack_cc2cpu && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_ack"}, {31'd0, bus.ack_cc2cpu}, 32'd1);
    check_eq({tag, "_lat"}, 32'(cyc - t_req), 32'(exp_lat));
    if (is_rd) check_eq({tag, "_dat"}, bus.dat_cc2cpu, exp_dat);
    if (is_hit) check_eq({tag, "_nomem"}, 32'(mem_cyc - m_req), 32'd0);
    repeat (hold) begin
      @(negedge clk);
      if (bus.ack_cc2cpu) extra++;
    end
    if (hold > 0) check_eq({tag, "_extra_ack"}, 32'(extra), 32'd0);
    bus.req_cpu2cc = 1'b0;
    @(negedge clk);
    check_eq({tag, "_ack_drop"}, {31'd0, bus.ack_cc2cpu}, 32'd0);
    check_eq({tag, "_dat_zero"}, bus.dat_cc2cpu, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem_m[i] = 32'h1000_0000 + 32'(i);
    mem_m[64] = 32'hA0; mem_m[65] = 32'hA1; mem_m[66] = 32'hA2; mem_m[67] = 32'hA3;
    bus.req_cpu2cc = 1'b0; bus.adr_cpu2cc = '0; bus.dat_cpu2cc = '0; bus.rdwr_cpu2cc = 1'b0;
    bus.ack_mem2cc = 1'b0; bus.dat_mem2cc = '0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_ack", {31'd0, bus.ack_cc2cpu}, 32'd0);
    check_eq("rst_dat", bus.dat_cc2cpu, 32'd0);
    check_eq("rst_req", {31'd0, bus.req_cc2mem}, 32'd0);
    check_eq("rst_wr", {31'd0, bus.wr_cc2mem}, 32'd0);
    check_eq("rst_adr", bus.adr_cc2mem, 32'd0);
    check_eq("rst_mdat", bus.dat_cc2mem, 32'd0);
    check_eq("rst_state", {29'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Cold miss then same-line hit.
    cpu_start(32'h108, 32'h0, 1'b0);
    mem_serve(4, 1'b0, 32'h100, 0, 1'b0);
    wait_ack("rd108", 0, 1'b1, 32'hA2, 6, 1'b0);
    cpu_start(32'h10C, 32'h0, 1'b0);
    wait_ack("rd10c", 0, 1'b1, 32'hA3, 2, 1'b1);

    // Write hit marks the line dirty.
    cpu_start(32'h108, 32'hDEADBEEF, 1'b1);
    wait_ack("wr108", 0, 1'b0, 32'h0, 2, 1'b1);
    cpu_start(32'h108, 32'h0, 1'b0);
    wait_ack("rd108b", 0, 1'b1, 32'hDEADBEEF, 2, 1'b1);

    // Fill the remaining ways of set 0x10.
    cpu_start(32'h508, 32'h0, 1'b0);
    mem_serve(4, 1'b0, 32'h500, 0, 1'b0);
    wait_ack("rd508", 0, 1'b1, 32'h1000_0142, 6, 1'b0);
    cpu_start(32'h908, 32'h0, 1'b0);
    mem_serve(4, 1'b0, 32'h900, 0, 1'b0);
    wait_ack("rd908", 0, 1'b1, 32'h1000_0242, 6, 1'b0);
    cpu_start(32'hD08, 32'h0, 1'b0);
    mem_serve(4, 1'b0, 32'hD00, 0, 1'b0);
    wait_ack("rdd08", 0, 1'b1, 32'h1000_0342, 6, 1'b0);

    // Set full: round-robin picks way 0, which is dirty.
    exp_q.push_back(32'hA0); exp_q.push_back(32'hA1);
    exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'hA3);
    cpu_start(32'h1108, 32'h0, 1'b0);
    mem_serve(4, 1'b1, 32'h100, 0, 1'b0);
    mem_serve(4, 1'b0, 32'h1100, 0, 1'b1);
    wait_ack("rd1108", 0, 1'b1, 32'h1000_0442, 10, 1'b0);
    check_eq("wb_q_empty", 32'(exp_q.size()), 32'd0);
    cpu_start(32'h504, 32'h0, 1'b0);
    wait_ack("rd504", 0, 1'b1, 32'h1000_0141, 2, 1'b1);

    // Refill with 5 idle cycles between acks.
    cpu_start(32'h208, 32'h0, 1'b0);
    mem_serve(4, 1'b0, 32'h200, 5, 1'b0);
    wait_ack("rd208", 0, 1'b1, 32'h1000_0082, 21, 1'b0);

    // Request held 4 cycles past its ack.
    cpu_start(32'h20C, 32'h0, 1'b0);
    wait_ack("rd20c", 4, 1'b1, 32'h1000_0083, 2, 1'b1);

    // Reset during the second refill word.
    cpu_start(32'h308, 32'h0, 1'b0);
    mem_serve(1, 1'b0, 32'h300, 0, 1'b0);
    check_eq("rstm_adr", bus.adr_cc2mem, 32'h304);
    bus.dat_mem2cc = mem_m[12'h0C1];
    bus.ack_mem2cc = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    bus.ack_mem2cc = 1'b0;
    rst = 1'b0;
    bus.req_cpu2cc = 1'b0;
    check_eq("rstm_req", {31'd0, bus.req_cc2mem}, 32'd0);
    check_eq("rstm_ack", {31'd0, bus.ack_cc2cpu}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check_eq("rstm_noack", {31'd0, bus.ack_cc2cpu}, 32'd0);
    end
    cpu_start(32'h308, 32'h0, 1'b0);
    mem_serve(4, 1'b0, 32'h300, 0, 1'b0);
    wait_ack("rd308", 0, 1'b1, 32'h1000_00C2, 6, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
